// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC owner and fetch/issue/exec sequencer for the 8-bit core
module branch_sequencer #(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter int         FETCH_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_valid,
    input  logic [7:0] imem_data,
    output logic [7:0] instr,
    output logic       instr_valid,
    input  logic       exec_done,
    input  logic [7:0] r0,
    input  logic [7:0] r3,
    input  logic       halt,
    output logic [7:0] pc,
    output logic       branch_taken,
    output logic       running,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       is_cond;
    logic       r3_neg;
    logic       r3_zero;
    logic       cond_true;
    logic       halt_entry;
    logic       timeout_hit;

    assign is_cond     = (instr[7:6] == 2'b11);
    assign r3_neg      = r3[7];
    assign r3_zero     = (r3 == 8'h00);
    // Halt is only honoured before the first request cycle of a fetch.
    assign halt_entry  = (state == S_FETCH) && (wait_cnt == 8'h00) && halt;
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        cond_true = 1'b0;
        case (instr[2:0])
            3'b000: cond_true = 1'b0;
            3'b001: cond_true = r3_zero;
            3'b010: cond_true = r3_neg;
            3'b011: cond_true = r3_neg | r3_zero;
            3'b100: cond_true = 1'b1;
            3'b101: cond_true = ~r3_zero;
            3'b110: cond_true = ~r3_neg;
            3'b111: cond_true = ~r3_neg & ~r3_zero;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            instr    <= 8'h00;
            wait_cnt <= 8'h00;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: begin
                    if (!halt_entry) begin
                        if (imem_valid) begin
                            instr    <= imem_data;
                            wait_cnt <= 8'h00;
                        end else if (timeout_hit) begin
                            fault <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (is_cond) begin
                        pc <= cond_true ? r0 : pc + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        pc <= pc + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (halt_entry) begin
                    state_next = S_HALTED;
                end else if (imem_valid) begin
                    state_next = S_ISSUE;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_ISSUE:  state_next = is_cond ? S_FETCH : S_EXEC;
            S_EXEC:   state_next = exec_done ? S_FETCH : S_EXEC;
            S_HALTED: state_next = halt ? S_HALTED : S_FETCH;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req     = (state == S_FETCH) && !halt_entry;
        imem_addr    = pc;
        instr_valid  = (state == S_ISSUE) && !is_cond;
        branch_taken = (state == S_ISSUE) && is_cond && cond_true;
        running      = (state == S_FETCH) || (state == S_ISSUE) || (state == S_EXEC);
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - directed and randomized checks of branch_sequencer against a phase model
module tb_branch_sequencer;

    localparam logic [7:0] RST_PC  = 8'h10;
    localparam int         TIMEOUT = 4;

    localparam int P_FETCH  = 0;
    localparam int P_ISSUE  = 1;
    localparam int P_EXEC   = 2;
    localparam int P_HALTED = 3;
    localparam int P_FAULT  = 4;

    logic       clk;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       exec_done;
    logic [7:0] r0;
    logic [7:0] r3;
    logic       halt;
    logic [7:0] pc;
    logic       branch_taken;
    logic       running;
    logic       fault;

    int n_total = 0;
    int n_pass  = 0;

    branch_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .r0(r0), .r3(r3),
        .halt(halt), .pc(pc), .branch_taken(branch_taken), .running(running),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic cond_holds(input logic [2:0] c, input logic [7:0] v);
        int s;
        s = int'($signed(v));
        case (c)
            3'd0: return 1'b0;
            3'd1: return s == 0;
            3'd2: return s < 0;
            3'd3: return s <= 0;
            3'd4: return 1'b1;
            3'd5: return s != 0;
            3'd6: return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    // Model: architectural PC plus which step of the instruction cycle we are in.
    int         m_phase;
    int         m_wait;
    logic [7:0] m_pc;
    logic [7:0] m_instr;
    logic       m_fault;
    bit         m_live = 0;

    always @(negedge clk) begin
        logic e_req, e_iv, e_bt, e_run, t;
        if (reset) begin
            m_live  = 1;
            m_phase = P_FETCH;
            m_wait  = 0;
            m_pc    = RST_PC;
            m_instr = 8'h00;
            m_fault = 1'b0;
        end else if (m_live) begin
            e_req = 0; e_iv = 0; e_bt = 0; e_run = 0;
            chk8("m_pc", pc, m_pc);
            chk8("m_instr", instr, m_instr);
            chk1("m_fault", fault, m_fault);
            case (m_phase)
                P_FETCH: begin
                    e_run = 1;
                    if (m_wait == 0 && halt) begin
                        m_phase = P_HALTED;
                    end else begin
                        e_req = 1;
                        chk8("m_addr", imem_addr, m_pc);
                        if (imem_valid) begin
                            m_instr = imem_data;
                            m_wait  = 0;
                            m_phase = P_ISSUE;
                        end else if (m_wait + 1 == TIMEOUT) begin
                            m_fault = 1'b1;
                            m_phase = P_FAULT;
                        end else begin
                            m_wait++;
                        end
                    end
                end
                P_ISSUE: begin
                    e_run = 1;
                    if (m_instr[7:6] == 2'b11) begin
                        t     = cond_holds(m_instr[2:0], r3);
                        e_bt  = t;
                        m_pc  = t ? r0 : 8'(m_pc + 1);
                        m_phase = P_FETCH;
                    end else begin
                        e_iv    = 1;
                        m_phase = P_EXEC;
                    end
                end
                P_EXEC: begin
                    e_run = 1;
                    if (exec_done) begin
                        m_pc    = 8'(m_pc + 1);
                        m_phase = P_FETCH;
                    end
                end
                P_HALTED: if (!halt) m_phase = P_FETCH;
                default: ;
            endcase
            chk1("m_req", imem_req, e_req);
            chk1("m_iv", instr_valid, e_iv);
            chk1("m_bt", branch_taken, e_bt);
            chk1("m_run", running, e_run);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_nonbranch(input logic [7:0] a);
        exec_done = 0; imem_valid = 1; imem_data = 8'h40;
        #4;
        chk1("nb_req", imem_req, 1'b1);
        chk8("nb_addr", imem_addr, a);
        tick();
        imem_valid = 0;
        #4;
        chk1("nb_iv", instr_valid, 1'b1);
        chk8("nb_instr", instr, 8'h40);
        tick();
        exec_done = 1;
        tick();
        exec_done = 0;
    endtask

    task automatic run_branch(input logic [7:0] op, input logic [7:0] r0v, input logic [7:0] r3v,
                              input logic [7:0] a, input logic taken);
        exec_done = 0; imem_valid = 1; imem_data = op; r0 = r0v; r3 = r3v;
        #4;
        chk1("br_req", imem_req, 1'b1);
        chk8("br_addr", imem_addr, a);
        tick();
        imem_valid = 0;
        #4;
        chk1("br_taken", branch_taken, taken);
        chk1("br_no_iv", instr_valid, 1'b0);
        tick();
    endtask

    logic [2:0] tbl [8];
    logic [7:0] sweep_r3 [3];
    logic [7:0] cur;

    initial begin
        tbl      = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b111, 3'b110, 3'b011, 3'b010};
        sweep_r3 = '{8'h00, 8'h01, 8'hFF};
        reset = 1; imem_valid = 0; imem_data = 0; exec_done = 0; r0 = 0; r3 = 0; halt = 0;
        tick();
        tick();
        reset = 0;
        #4;
        chk8("rst_pc", pc, 8'h10);
        chk8("rst_addr", imem_addr, 8'h10);
        chk1("rst_req", imem_req, 1'b1);
        chk1("rst_fault", fault, 1'b0);
        chk8("rst_instr", instr, 8'h00);
        chk1("rst_iv", instr_valid, 1'b0);
        chk1("rst_bt", branch_taken, 1'b0);
        tick();

        run_nonbranch(8'h10);
        run_nonbranch(8'h11);
        run_nonbranch(8'h12);
        run_branch(8'hC4, 8'h05, 8'h00, 8'h13, 1'b1);
        run_branch(8'hC2, 8'h37, 8'h80, 8'h05, 1'b1);
        run_branch(8'hC4, 8'h05, 8'h00, 8'h37, 1'b1);
        run_branch(8'hC2, 8'h37, 8'h7F, 8'h05, 1'b0);
        cur = 8'h06;

        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                run_branch(8'hC0 | 8'(c), cur, sweep_r3[k], cur, tbl[c][k]);
                if (!tbl[c][k]) cur = cur + 8'd1;
            end
        end

        run_branch(8'hC4, 8'hFF, 8'h00, cur, 1'b1);
        run_nonbranch(8'hFF);

        imem_valid = 1; imem_data = 8'h40;
        #4;
        chk8("wrap_addr", imem_addr, 8'h00);
        tick();
        imem_valid = 0; halt = 1;
        tick();
        exec_done = 1;
        tick();
        exec_done = 0;
        #4;
        chk1("halt_entry_req", imem_req, 1'b0);
        chk8("halt_pc", pc, 8'h01);
        tick();
        #4;
        chk1("halted_req", imem_req, 1'b0);
        chk1("halted_run", running, 1'b0);
        tick();
        halt = 0;
        tick();
        #4;
        chk1("resume_req", imem_req, 1'b1);
        chk8("resume_addr", imem_addr, 8'h01);
        chk1("resume_run", running, 1'b1);

        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            #4;
            chk1("to_wait_req", imem_req, 1'b1);
        end
        tick();
        #4;
        chk1("to_fault", fault, 1'b1);
        chk1("to_req", imem_req, 1'b0);
        chk1("to_run", running, 1'b0);
        tick();
        tick();
        #4;
        chk1("to_sticky", fault, 1'b1);
        chk8("to_pc_hold", pc, 8'h01);
        tick();
        reset = 1;
        tick();
        reset = 0;
        #4;
        chk1("clr_fault", fault, 1'b0);
        chk8("clr_addr", imem_addr, 8'h10);
        tick();

        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            imem_valid = ($urandom_range(0, 9) < 7);
            imem_data  = 8'($urandom);
            exec_done  = ($urandom_range(0, 9) < 3);
            halt       = ($urandom_range(0, 9) == 0);
            r0         = 8'($urandom);
            r3         = 8'($urandom);
            tick();
        end
        reset = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Program-counter and instruction-sequencing controller for the 8-bit core.
- Fetches one instruction byte per step from instruction memory and issues it to the datapath.
- Evaluates condition-class instructions against R3 in-block and loads PC from R0 on a taken branch.
- Sits between instruction memory and the register/ALU datapath; owns PC.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
FETCH_TIMEOUT, 16, max cycles FETCH waits for imem_valid before faulting (range 1..255).

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, held high in FETCH until imem_valid
imem_addr  output  8  fetch address; equals pc whenever imem_req=1
imem_valid  input  1  instruction byte on imem_data valid this cycle
imem_data  input  8  fetched instruction byte
instr  output  8  latched instruction, stable from ISSUE until next fetch completes
instr_valid  output  1  one-cycle pulse in ISSUE, non-branch instructions only
exec_done  input  1  datapath finished the issued instruction
r0  input  8  branch target register value
r3  input  8  condition operand, signed two's complement
halt  input  1  stop at the next instruction boundary
pc  output  8  current program counter
branch_taken  output  1  one-cycle pulse when PC is loaded from r0
running  output  1  high in FETCH/ISSUE/EXEC
fault  output  1  sticky fetch-timeout flag

Behaviour:
- Reset (any state, mid-fetch included): pc=RESET_PC, state=FETCH. Outputs low except imem_req: fault=0, instr=0, instr_valid=0, branch_taken=0, timeout counter=0. imem_req=1 from the first cycle after reset.
- States: FETCH, ISSUE, EXEC, HALTED, FAULT. Encoding is free.
- FETCH entry check: if halt=1 in a cycle where state=FETCH and no request has been accepted yet, go to HALTED. imem_req is low in that cycle; halt wins over imem_valid.
- FETCH: imem_req=1, imem_addr=pc, counter increments each cycle.
  - On imem_valid: instr<=imem_data, counter clears, go to ISSUE.
  - If the counter reaches FETCH_TIMEOUT without imem_valid: go to FAULT, fault<=1.
- ISSUE: decode class = instr[7:6].
  - Class 2'b11 (condition): no instr_valid. Evaluate cond=instr[2:0] on r3 sampled this cycle:
    - 000 never; 001 r3==0; 010 r3<0; 011 r3<=0; 100 always; 101 r3!=0; 110 r3>=0; 111 r3>0.
    - Comparisons are signed, so 8'h80..8'hFF are negative.
    - Taken: pc<=r0, branch_taken=1 for 1 cycle.
    - Not taken: pc<=pc+1.
    - Next state: FETCH.
  - Other classes: instr_valid=1 for exactly one cycle, then EXEC.
- EXEC: wait for exec_done, then pc<=pc+1 and go to FETCH. exec_done outside EXEC is ignored.
- PC arithmetic is mod 256: 8'hFF+1 gives 8'h00, no flag.
- Branch to self (r0==pc) is legal.
- Latency:
  - Condition instruction: fetch-accept cycle + 1 ISSUE cycle, so the next imem_req appears 2 cycles after imem_valid.
  - Other instructions: 1 cycle after exec_done.
- HALTED: imem_req=0, running=0, pc holds. halt=0 returns to FETCH next cycle with the same pc.
- FAULT: all handshake outputs low, pc holds, exits only on reset.
- halt asserted during ISSUE or EXEC has no effect until the boundary.

Test Plan:
- Reset with RESET_PC=8'h10, memory returns 8'h40 with 0-cycle latency, exec_done 1 cycle after instr_valid -> imem_addr 10, 11, 12…; one instr_valid per instruction; pc steps by 1.
- Condition 8'hC2 (r3<0) with r3=8'h80, r0=8'h37 at pc=8'h05 -> branch_taken pulse, next imem_addr=8'h37, no instr_valid. Repeat with r3=8'h7F -> next addr 8'h06.
- Sweep all 8 conditions × r3 in {8'h00, 8'h01, 8'hFF} -> taken pattern matches the table, e.g. 111 taken only for 8'h01; 011 taken for 8'h00 and 8'hFF.
- pc=8'hFF with a non-branch instruction, exec_done -> pc=8'h00, fetch at 8'h00.
- Assert halt during EXEC -> completes, pc+1, enters HALTED (imem_req=0, running=0). Deassert -> fetch resumes at the same pc.
- FETCH_TIMEOUT=4, imem_valid never asserted -> fault=1 and imem_req=0 after 4 cycles; the state persists; reset clears fault and fetch restarts at RESET_PC.
